// File: rtl/norm_row_collector_if.sv
// Stream bundle between the normalizer, the row collector and its consumer.
// The normalizer side (norm_valid, psum_norm_1, psum_norm_2) has no ready:
// every beat with norm_valid high is consumed.
// The row side is valid/ready. A row transfers on any rising edge where
// row_valid && row_ready. row_valid never depends on row_ready, and
// row_data is held stable while row_valid && !row_ready.
interface norm_row_collector_if #(
   parameter int BW_PSUM = 11,
   parameter int COL     = 8
);
   logic                       norm_valid;
   logic [BW_PSUM-1:0]         psum_norm_1;
   logic [BW_PSUM-1:0]         psum_norm_2;
   logic [2*COL*BW_PSUM-1:0]   row_data;
   logic                       row_valid;
   logic                       row_ready;

   // Environment view: drives the normalizer beats and the downstream accept.
   modport master (
      output norm_valid, psum_norm_1, psum_norm_2, row_ready,
      input  row_data, row_valid
   );

   // Collector view.
   modport slave (
      input  norm_valid, psum_norm_1, psum_norm_2, row_ready,
      output row_data, row_valid
   );
endinterface

// File: rtl/norm_row_collector.sv
// norm_row_collector: assembles per-beat normalized elements from two cores
// into full rows. Core-1 lanes fill the low half of a row and core-2 lanes
// fill the high half. Completed rows are queued in a small FIFO and offered
// downstream over valid/ready. The normalizer cannot be stalled, so a row
// that arrives while the FIFO is full is dropped, and a sticky overflow
// flag records the drop.
// Optional build macro NORM_ROW_COLLECTOR_ROWCNT_EN adds a 16-bit row_count
// output that counts rows accepted into the FIFO. clr_ovf clears it.
// The interface parameters must match BW_PSUM/COL of this module.
module norm_row_collector #(
   parameter int BW_PSUM = 11,
   parameter int COL     = 8,
   parameter int DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   norm_row_collector_if.slave  bus,
   input  logic                 flush,
   input  logic                 clr_ovf,
   output logic                 busy,
   output logic                 overflow
`ifdef NORM_ROW_COLLECTOR_ROWCNT_EN
   ,
   output logic [15:0]          row_count
`endif
);

   localparam int RW = 2 * COL * BW_PSUM;
   localparam int LW = (COL > 1) ? $clog2(COL) : 1;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [LW-1:0] LAST_LANE = LW'(COL - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

   // Assembly state
   logic [LW-1:0] lane_q, lane_d;
   logic [RW-1:0] asm_q, asm_d;

   // Row FIFO state
   logic [RW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   // Sticky drop flag
   logic          ovf_q, ovf_d;

   // Per-cycle decode
   logic          beat;
   logic          complete;
   logic          push;
   logic          pop;
   logic          full;
   logic          accept;
   logic          drop;
   logic [RW-1:0] row_cur;

   assign beat     = bus.norm_valid;
   assign complete = beat && (lane_q == LAST_LANE);
   // A flush only pushes if there is something in the row: either lanes
   // already collected or a beat landing in this same cycle. A flush on the
   // completing beat folds into that single push.
   assign push     = complete || (flush && ((lane_q != '0) || beat));
   assign full     = (count_q == DEPTH_C);
   assign pop      = (count_q != '0) && bus.row_ready;
   // A pop in the same cycle frees the head slot, so a full FIFO can still
   // take the new row. The write slot equals the slot being read out.
   assign accept   = push && (!full || pop);
   assign drop     = push && full && !pop;

   // Current row including this cycle's beat. Lanes not yet written hold
   // zero because the assembly register is cleared after every push.
   always_comb begin
      row_cur = asm_q;
      if (beat) begin
         for (int k = 0; k < COL; k++) begin
            if (lane_q == LW'(k)) begin
               row_cur[k*BW_PSUM +: BW_PSUM]       = bus.psum_norm_1;
               row_cur[(COL+k)*BW_PSUM +: BW_PSUM] = bus.psum_norm_2;
            end
         end
      end
   end

   // Next lane index and assembly contents; both restart after any push,
   // including a dropped one.
   always_comb begin
      lane_d = lane_q;
      asm_d  = asm_q;
      if (push) begin
         lane_d = '0;
         asm_d  = '0;
      end else if (beat) begin
         lane_d = lane_q + LW'(1);
         asm_d  = row_cur;
      end
   end

   // FIFO pointer and occupancy update.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (accept) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (accept && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!accept && pop) begin
         count_d = count_q - CW'(1);
      end
   end

   // Overflow flag: a drop outranks a clear in the same cycle.
   always_comb begin
      ovf_d = ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   // Assembly, pointer and flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_q   <= '0;
         asm_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         lane_q   <= lane_d;
         asm_q    <= asm_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Row storage. It is cleared on reset so that row_data reads zero
   // out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (accept) begin
         mem_q[wr_ptr_q] <= row_cur;
      end
   end

`ifdef NORM_ROW_COLLECTOR_ROWCNT_EN
   logic [15:0] rc_q, rc_d;

   // Accepted-row counter: clr_ovf restarts it, and an accept in the
   // clearing cycle counts as the first row.
   always_comb begin
      rc_d = rc_q;
      if (clr_ovf) begin
         rc_d = accept ? 16'd1 : 16'd0;
      end else if (accept) begin
         rc_d = rc_q + 16'd1;
      end
   end

   // Accepted-row counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rc_q <= '0;
      end else begin
         rc_q <= rc_d;
      end
   end

   assign row_count = rc_q;
`endif

   assign bus.row_data  = mem_q[rd_ptr_q];
   assign bus.row_valid = (count_q != '0);
   assign busy          = (lane_q != '0);
   assign overflow      = ovf_q;

endmodule

// File: tb/tb_norm_row_collector.sv
// Directed bench for norm_row_collector. Expected rows are queued when
// stimulus is issued; a negedge monitor pops and compares every row the
// DUT hands over.
module tb_norm_row_collector;

   localparam int BW    = 11;
   localparam int COL   = 8;
   localparam int DEPTH = 4;
   localparam int RW    = 2 * COL * BW;

   logic clk;
   logic rst_n;
   logic flush;
   logic clr_ovf;
   logic busy;
   logic overflow;
`ifdef NORM_ROW_COLLECTOR_ROWCNT_EN
   logic [15:0] row_count;
`endif

   int checks = 0;
   int errors = 0;

   logic [RW-1:0] exp_q[$];
   logic [RW-1:0] last_row;
   logic [RW-1:0] exp_row;
   logic [RW-1:0] held;

   norm_row_collector_if #(.BW_PSUM(BW), .COL(COL)) bus ();

   norm_row_collector #(.BW_PSUM(BW), .COL(COL), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .flush    (flush),
      .clr_ovf  (clr_ovf),
      .busy     (busy),
      .overflow (overflow)
`ifdef NORM_ROW_COLLECTOR_ROWCNT_EN
      ,
      .row_count(row_count)
`endif
   );

   // Clock and global time limit
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL timeout bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   // Monitor: every handed-over row must match the oldest expected row.
   always @(negedge clk) begin
      if (rst_n && bus.row_valid && bus.row_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL row_unexpected got %h expected none", bus.row_data);
         end else begin
            logic [RW-1:0] e;
            e = exp_q.pop_front();
            if (bus.row_data !== e) begin
               errors++;
               $display("FAIL row_data got %h expected %h", bus.row_data, e);
            end
         end
         last_row = bus.row_data;
      end
   end

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_beat(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic fl);
      bus.norm_valid  = 1'b1;
      bus.psum_norm_1 = a;
      bus.psum_norm_2 = b;
      flush           = fl;
      tick();
      bus.norm_valid  = 1'b0;
      flush           = 1'b0;
   endtask

   // Expected full row where lane k = b1+k and lane COL+k = b2+k.
   function automatic logic [RW-1:0] mk_full(input int b1, input int b2);
      logic [RW-1:0] r;
      r = '0;
      for (int k = 0; k < COL; k++) begin
         r[k*BW +: BW]       = BW'(b1 + k);
         r[(COL+k)*BW +: BW] = BW'(b2 + k);
      end
      return r;
   endfunction

   task automatic send_full(input int b1, input int b2);
      for (int k = 0; k < COL; k++) begin
         drive_beat(BW'(b1 + k), BW'(b2 + k), 1'b0);
      end
   endtask

   task automatic pulse_clr();
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
   endtask

   task automatic drain();
      int n;
      bus.row_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         tick();
         n++;
      end
      chk("drain_left", exp_q.size(), 0);
      tick();
      chk("drain_valid", bus.row_valid, 1'b0);
      bus.row_ready = 1'b0;
   endtask

   initial begin
      rst_n           = 1'b0;
      flush           = 1'b0;
      clr_ovf         = 1'b0;
      bus.norm_valid  = 1'b0;
      bus.psum_norm_1 = '0;
      bus.psum_norm_2 = '0;
      bus.row_ready   = 1'b0;
      last_row        = '0;
      repeat (3) tick();

      // Reset state
      chk("rst_row_valid", bus.row_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      checks++;
      if (bus.row_data !== '0) begin
         errors++;
         $display("FAIL rst_row_data got %h expected 0", bus.row_data);
      end
`ifdef NORM_ROW_COLLECTOR_ROWCNT_EN
      chk("rst_row_count", row_count, 0);
`endif
      rst_n = 1'b1;
      tick();

      // Full row with 1-cycle latency and busy tracking
      bus.row_ready = 1'b1;
      exp_q.push_back(mk_full(1, 'h100));
      for (int k = 0; k < COL; k++) begin
         bus.norm_valid  = 1'b1;
         bus.psum_norm_1 = BW'(k + 1);
         bus.psum_norm_2 = BW'('h100 + k);
         chk($sformatf("busy_beat%0d", k), busy, (k != 0));
         if (k == COL - 1) chk("valid_before_last", bus.row_valid, 1'b0);
         tick();
      end
      bus.norm_valid = 1'b0;
      chk("valid_after_last", bus.row_valid, 1'b1);
      chk("busy_after_row", busy, 1'b0);
      tick();
      chk("lane0", last_row[0*BW +: BW], 'h001);
      chk("lane7", last_row[7*BW +: BW], 'h008);
      chk("lane8", last_row[8*BW +: BW], 'h100);
      chk("lane15", last_row[15*BW +: BW], 'h107);
      chk("valid_one_cycle", bus.row_valid, 1'b0);

      // Partial row closed by flush, then a flush with nothing pending
      exp_row = '0;
      exp_row[0*BW +: BW] = 11'd5;
      exp_row[1*BW +: BW] = 11'd6;
      exp_row[2*BW +: BW] = 11'd7;
      exp_q.push_back(exp_row);
      drive_beat(11'd5, 11'd0, 1'b0);
      drive_beat(11'd6, 11'd0, 1'b0);
      drive_beat(11'd7, 11'd0, 1'b0);
      chk("busy_partial", busy, 1'b1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("busy_after_flush", busy, 1'b0);
      chk("valid_after_flush", bus.row_valid, 1'b1);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      chk("empty_flush_noop", bus.row_valid, 1'b0);

      // Flush with a same-cycle beat includes that beat
      exp_row = '0;
      exp_row[0*BW +: BW]       = 11'h011;
      exp_row[1*BW +: BW]       = 11'h022;
      exp_row[(COL+0)*BW +: BW] = 11'h3aa;
      exp_row[(COL+1)*BW +: BW] = 11'h3bb;
      exp_q.push_back(exp_row);
      drive_beat(11'h011, 11'h3aa, 1'b0);
      drive_beat(11'h022, 11'h3bb, 1'b1);
      chk("busy_flush_beat", busy, 1'b0);
      tick();

      // Flush on the completing beat produces exactly one row
      exp_q.push_back(mk_full('h040, 'h540));
      for (int k = 0; k < COL; k++) begin
         drive_beat(BW'('h040 + k), BW'('h540 + k), (k == COL - 1));
      end
      repeat (3) tick();
      chk("flush_complete_single", bus.row_valid, 1'b0);

      // Backpressure: 4 rows held, 5th dropped
      bus.row_ready = 1'b0;
      for (int r = 0; r < 5; r++) begin
         if (r < DEPTH) exp_q.push_back(mk_full(r * 16, 'h200 + r * 16));
         send_full(r * 16, 'h200 + r * 16);
         if (r == DEPTH - 1) chk("ovf_before_drop", overflow, 1'b0);
      end
      chk("ovf_after_drop", overflow, 1'b1);
      chk("valid_full", bus.row_valid, 1'b1);
      held = bus.row_data;
      repeat (2) tick();
      checks++;
      if (bus.row_data !== held) begin
         errors++;
         $display("FAIL row_stable got %h expected %h", bus.row_data, held);
      end
      drain();
      chk("ovf_sticky", overflow, 1'b1);
      pulse_clr();
      chk("ovf_cleared", overflow, 1'b0);

      // Push and pop together while full
      for (int r = 0; r < DEPTH; r++) begin
         exp_q.push_back(mk_full('h080 + r * 8, 'h600 + r * 8));
         send_full('h080 + r * 8, 'h600 + r * 8);
      end
      exp_q.push_back(mk_full('h0f0, 'h700));
      for (int k = 0; k < COL - 1; k++) begin
         drive_beat(BW'('h0f0 + k), BW'('h700 + k), 1'b0);
      end
      bus.row_ready = 1'b1;
      drive_beat(BW'('h0f0 + COL - 1), BW'('h700 + COL - 1), 1'b0);
      bus.row_ready = 1'b0;
      chk("ovf_push_pop_full", overflow, 1'b0);
      send_full('h1f0, 'h7f0);
      chk("still_full_drop", overflow, 1'b1);
      drain();
      pulse_clr();
      chk("ovf_cleared2", overflow, 1'b0);

      // Asynchronous reset mid-row with rows queued
      exp_q.push_back(mk_full('h300, 'h310));
      exp_q.push_back(mk_full('h320, 'h330));
      send_full('h300, 'h310);
      send_full('h320, 'h330);
      for (int k = 0; k < 4; k++) begin
         drive_beat(11'h7ff, 11'h7ff, 1'b0);
      end
      chk("busy_mid_row", busy, 1'b1);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("arst_row_valid", bus.row_valid, 1'b0);
      chk("arst_busy", busy, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      exp_q.push_back(mk_full('h010, 'h410));
      bus.row_ready = 1'b1;
      send_full('h010, 'h410);
      drain();

`ifdef NORM_ROW_COLLECTOR_ROWCNT_EN
      // Accepted-row counter: drops are not counted
      exp_q.push_back(mk_full('h050, 'h450));
      send_full('h050, 'h450);
      pulse_clr();
      chk("rc_after_clr", row_count, 0);
      for (int r = 0; r < 3; r++) begin
         exp_q.push_back(mk_full('h060 + r * 8, 'h460 + r * 8));
         send_full('h060 + r * 8, 'h460 + r * 8);
      end
      send_full('h0a0, 'h4a0);
      chk("rc_ovf", overflow, 1'b1);
      chk("rc_three", row_count, 3);
      pulse_clr();
      chk("rc_cleared", row_count, 0);
      drain();
`endif

      tick();
      chk("final_queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
